// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants, state encoding, Rcon table and RotWord helper
package aes_pkg;

   localparam int AES_NR    = 10;
   localparam int AES_KEY_W = 128;
   localparam int AES_EXP_W = AES_KEY_W * (AES_NR + 1);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } kx_state_e;

   // Round constant for rounds 1..10; zero outside that range.
   function automatic logic [7:0] aes_rcon(input logic [3:0] r);
      case (r)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [31:0] aes_rot_word(input logic [31:0] w);
      return {w[7:0], w[31:8]};
   endfunction

endpackage

// File: rtl/aes_key_expand_seq_if.sv
// rtl/aes_key_expand_seq_if.sv - key schedule request/result bundle; AES_KEY_STREAM_EN adds the per-round key stream
interface aes_key_expand_seq_if;
   import aes_pkg::*;

   logic                 start;
   logic [AES_KEY_W-1:0] key;
   logic                 busy;
   logic                 done;
   logic                 key_valid;
   logic [AES_EXP_W-1:0] expanded_key;
`ifdef AES_KEY_STREAM_EN
   logic                 rk_valid;
   logic [3:0]           rk_idx;
   logic [AES_KEY_W-1:0] rk;

   modport master (
      output start, key,
      input  busy, done, key_valid, expanded_key, rk_valid, rk_idx, rk
   );
   modport slave (
      input  start, key,
      output busy, done, key_valid, expanded_key, rk_valid, rk_idx, rk
   );
`else
   modport master (
      output start, key,
      input  busy, done, key_valid, expanded_key
   );
   modport slave (
      input  start, key,
      output busy, done, key_valid, expanded_key
   );
`endif

endinterface

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational AES forward S-box, one byte
module aes_sbox (
   input  logic [7:0] data,
   output logic [7:0] sub
);

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   assign sub = SBOX[data];

endmodule

// File: rtl/aes_key_expand_seq.sv
// rtl/aes_key_expand_seq.sv - iterative AES-128 key schedule, one round key per clock
// Optional macro AES_KEY_STREAM_EN adds the rk_valid/rk_idx/rk round key stream.
module aes_key_expand_seq
   import aes_pkg::*;
#(
   parameter int NR    = AES_NR,
   parameter int KEY_W = AES_KEY_W
) (
   input  logic                clk,
   input  logic                rst_n,
   aes_key_expand_seq_if.slave bus
);

   if (NR != 10 || KEY_W != 128) begin : g_cfg_err
      $error("aes_key_expand_seq: only NR=10 and KEY_W=128 are supported");
   end

   kx_state_e              state;
   logic [3:0]             round_cnt;
   logic                   busy_q;
   logic                   done_q;
   logic                   key_valid_q;
   logic [KEY_W-1:0]       slot [NR+1];
   logic [KEY_W-1:0]       cur_rk;
   logic [KEY_W-1:0]       next_rk;
   logic [31:0]            rot_w3;
   logic [31:0]            sub_word;
   logic [31:0]            nw0, nw1, nw2, nw3;
   logic [KEY_W*(NR+1)-1:0] exp_flat;
`ifdef AES_KEY_STREAM_EN
   logic                   rk_valid_q;
   logic [3:0]             rk_idx_q;
   logic [KEY_W-1:0]       rk_q;
`endif

   // cur_rk mirrors the most recently written slot, so no read mux over the slots is needed.
   assign rot_w3 = aes_rot_word(cur_rk[127:96]);

   for (genvar b = 0; b < 4; b++) begin : g_sbox
      aes_sbox u_sbox (
         .data (rot_w3[8*b +: 8]),
         .sub  (sub_word[8*b +: 8])
      );
   end

   assign nw0     = cur_rk[31:0] ^ sub_word ^ {24'h0, aes_rcon(round_cnt)};
   assign nw1     = cur_rk[63:32] ^ nw0;
   assign nw2     = cur_rk[95:64] ^ nw1;
   assign nw3     = cur_rk[127:96] ^ nw2;
   assign next_rk = {nw3, nw2, nw1, nw0};

   always_comb begin
      exp_flat = '0;
      for (int i = 0; i <= NR; i++) begin
         exp_flat[KEY_W*i +: KEY_W] = slot[i];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         round_cnt   <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         key_valid_q <= 1'b0;
         cur_rk      <= '0;
         for (int i = 0; i <= NR; i++) begin
            slot[i] <= '0;
         end
`ifdef AES_KEY_STREAM_EN
         rk_valid_q  <= 1'b0;
         rk_idx_q    <= '0;
         rk_q        <= '0;
`endif
      end else begin
         done_q <= 1'b0;
`ifdef AES_KEY_STREAM_EN
         rk_valid_q <= 1'b0;
`endif
         case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  slot[0]     <= bus.key;
                  cur_rk      <= bus.key;
                  round_cnt   <= 4'd1;
                  busy_q      <= 1'b1;
                  key_valid_q <= 1'b0;
                  state       <= ST_RUN;
`ifdef AES_KEY_STREAM_EN
                  rk_valid_q  <= 1'b1;
                  rk_idx_q    <= 4'd0;
                  rk_q        <= bus.key;
`endif
               end
            end
            ST_RUN: begin
               for (int i = 1; i <= NR; i++) begin
                  if (round_cnt == 4'(i)) slot[i] <= next_rk;
               end
               cur_rk <= next_rk;
`ifdef AES_KEY_STREAM_EN
               rk_valid_q <= 1'b1;
               rk_idx_q   <= round_cnt;
               rk_q       <= next_rk;
`endif
               if (round_cnt == 4'(NR)) begin
                  busy_q      <= 1'b0;
                  done_q      <= 1'b1;
                  key_valid_q <= 1'b1;
                  round_cnt   <= '0;
                  state       <= ST_IDLE;
               end else begin
                  round_cnt <= round_cnt + 4'd1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
   assign bus.key_valid    = key_valid_q;
   assign bus.expanded_key = exp_flat;
`ifdef AES_KEY_STREAM_EN
   assign bus.rk_valid     = rk_valid_q;
   assign bus.rk_idx       = rk_idx_q;
   assign bus.rk           = rk_q;
`endif

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// tb/tb_aes_key_expand_seq.sv - directed self-checking bench for aes_key_expand_seq
module tb_aes_key_expand_seq;

   localparam logic [127:0] FIPS_KEY    = 128'h3c4fcf098815f7aba6d2ae2816157e2b;
   localparam logic [127:0] FIPS_SLOT1  = 128'h05766c2a3939a323b12c548817fefaa0;
   localparam logic [127:0] FIPS_SLOT10 = 128'ha60c63b6c80c3fe18925eec9a8f914d0;
   localparam logic [127:0] ZERO_SLOT1  = 128'h63636362636363626363636263636362;
   localparam logic [127:0] ZERO_SLOT10 = 128'h8e188f6fcf51e92311e2923ecb5befb4;
   localparam logic [127:0] SEQ_KEY     = 128'h100F0E0D0C0B0A090807060504030201;
   localparam logic [127:0] ALT_KEY     = 128'hdeadbeef0123456789abcdeffedcba98;
   localparam logic [127:0] KEY_B       = 128'hffeeddccbbaa99887766554433221100;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   aes_key_expand_seq_if bus ();

   aes_key_expand_seq dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0]   sb   [256];
   logic [127:0] gold [11];

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p  = 8'h00;
      logic [7:0] aa = a;
      logic [7:0] bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ aa;
         aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
         bb = {1'b0, bb[7:1]};
      end
      return p;
   endfunction

   // S-box derived from GF(2^8) inverse plus affine map, independent of the RTL table.
   task automatic build_sbox();
      logic [7:0] inv, r, s;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         if (x != 0) begin
            for (int y = 1; y < 256; y++) begin
               if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
         end
         r = inv;
         s = inv;
         for (int k = 0; k < 4; k++) begin
            r = {r[6:0], r[7]};
            s = s ^ r;
         end
         sb[x] = s ^ 8'h63;
      end
   endtask

   task automatic compute_gold(input logic [127:0] k);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[32*i +: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[7:0], t[31:8]};
            t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
            t[7:0] = t[7:0] ^ rc;
            rc = rc[7] ? ({rc[6:0], 1'b0} ^ 8'h1b) : {rc[6:0], 1'b0};
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++) gold[r] = {w[4*r+3], w[4*r+2], w[4*r+1], w[4*r]};
   endtask

   task automatic start_key(input logic [127:0] k);
      bus.key   = k;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (n < 20) begin
         @(posedge clk);
         #1;
         n++;
         if (bus.done) break;
      end
   endtask

   task automatic test_reset();
      bus.start = 1'b0;
      bus.key   = '0;
      rst_n     = 1'b0;
      #12;
      n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
      n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", bus.done); end
      n_cmp++; if (bus.key_valid !== 1'b0) begin n_err++; $display("FAIL reset_key_valid: got %b want 0", bus.key_valid); end
      n_cmp++; if (bus.expanded_key !== '0) begin n_err++; $display("FAIL reset_expanded_key: not all zero"); end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %b want 0", bus.busy); end
   endtask

   task automatic test_fips();
      int n;
      compute_gold(FIPS_KEY);
      start_key(FIPS_KEY);
      n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL fips_busy_e0: got %b want 1", bus.busy); end
      n_cmp++; if (bus.key_valid !== 1'b0) begin n_err++; $display("FAIL fips_kv_e0: got %b want 0", bus.key_valid); end
      wait_done(n);
      n_cmp++; if (n !== 10) begin n_err++; $display("FAIL fips_latency: got %0d want 10", n); end
      n_cmp++; if (bus.key_valid !== 1'b1) begin n_err++; $display("FAIL fips_key_valid: got %b want 1", bus.key_valid); end
      n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL fips_busy_end: got %b want 0", bus.busy); end
      n_cmp++; if (bus.expanded_key[0 +: 128] !== FIPS_KEY) begin n_err++; $display("FAIL fips_slot0: got %h want %h", bus.expanded_key[0 +: 128], FIPS_KEY); end
      n_cmp++; if (bus.expanded_key[128 +: 128] !== FIPS_SLOT1) begin n_err++; $display("FAIL fips_slot1: got %h want %h", bus.expanded_key[128 +: 128], FIPS_SLOT1); end
      n_cmp++; if (bus.expanded_key[1280 +: 128] !== FIPS_SLOT10) begin n_err++; $display("FAIL fips_slot10: got %h want %h", bus.expanded_key[1280 +: 128], FIPS_SLOT10); end
      for (int i = 2; i < 10; i++) begin
         n_cmp++;
         if (bus.expanded_key[128*i +: 128] !== gold[i]) begin
            n_err++; $display("FAIL fips_slot%0d: got %h want %h", i, bus.expanded_key[128*i +: 128], gold[i]);
         end
      end
      @(posedge clk);
      #1;
      n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL fips_done_width: got %b want 0", bus.done); end
      n_cmp++; if (bus.key_valid !== 1'b1) begin n_err++; $display("FAIL fips_kv_hold: got %b want 1", bus.key_valid); end
   endtask

   task automatic test_zero_key();
      int n;
      start_key('0);
      wait_done(n);
      n_cmp++; if (n !== 10) begin n_err++; $display("FAIL zero_latency: got %0d want 10", n); end
      n_cmp++; if (bus.expanded_key[128 +: 128] !== ZERO_SLOT1) begin n_err++; $display("FAIL zero_slot1: got %h want %h", bus.expanded_key[128 +: 128], ZERO_SLOT1); end
      n_cmp++; if (bus.expanded_key[1280 +: 128] !== ZERO_SLOT10) begin n_err++; $display("FAIL zero_slot10: got %h want %h", bus.expanded_key[1280 +: 128], ZERO_SLOT10); end
   endtask

   task automatic test_ignore_start();
      int dones;
      compute_gold(SEQ_KEY);
      start_key(SEQ_KEY);
      bus.key = ALT_KEY;
      dones   = 0;
      for (int c = 1; c <= 14; c++) begin
         if (c == 3 || c == 10) bus.start = 1'b1;
         @(posedge clk);
         #1;
         bus.start = 1'b0;
         if (bus.done) dones++;
         if (c == 10) begin
            n_cmp++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL ign_done_e10: got %b want 1", bus.done); end
         end
      end
      n_cmp++; if (dones !== 1) begin n_err++; $display("FAIL ign_done_count: got %0d want 1", dones); end
      n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL ign_busy: got %b want 0", bus.busy); end
      n_cmp++; if (bus.key_valid !== 1'b1) begin n_err++; $display("FAIL ign_key_valid: got %b want 1", bus.key_valid); end
      for (int i = 0; i < 11; i++) begin
         n_cmp++;
         if (bus.expanded_key[128*i +: 128] !== gold[i]) begin
            n_err++; $display("FAIL ign_slot%0d: got %h want %h", i, bus.expanded_key[128*i +: 128], gold[i]);
         end
      end
   endtask

   task automatic test_reset_mid_run();
      int n;
      start_key(FIPS_KEY);
      repeat (5) begin
         @(posedge clk);
         #1;
      end
      rst_n = 1'b0;
      #1;
      n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy: got %b want 0", bus.busy); end
      n_cmp++; if (bus.key_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_kv: got %b want 0", bus.key_valid); end
      n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL rst_mid_done: got %b want 0", bus.done); end
      n_cmp++; if (bus.expanded_key !== '0) begin n_err++; $display("FAIL rst_mid_expanded_key: not all zero"); end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      n_cmp++; if (bus.key_valid !== 1'b0) begin n_err++; $display("FAIL rst_after_kv: got %b want 0", bus.key_valid); end
      compute_gold(KEY_B);
      start_key(KEY_B);
      wait_done(n);
      n_cmp++; if (n !== 10) begin n_err++; $display("FAIL rst_restart_latency: got %0d want 10", n); end
      n_cmp++; if (bus.key_valid !== 1'b1) begin n_err++; $display("FAIL rst_restart_kv: got %b want 1", bus.key_valid); end
      for (int i = 0; i < 11; i++) begin
         n_cmp++;
         if (bus.expanded_key[128*i +: 128] !== gold[i]) begin
            n_err++; $display("FAIL rst_slot%0d: got %h want %h", i, bus.expanded_key[128*i +: 128], gold[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int n;
      compute_gold(SEQ_KEY);
      start_key(SEQ_KEY);
      wait_done(n);
      n_cmp++; if (n !== 10) begin n_err++; $display("FAIL b2b_first_latency: got %0d want 10", n); end
      n_cmp++; if (bus.expanded_key[1280 +: 128] !== gold[10]) begin n_err++; $display("FAIL b2b_first_slot10: got %h want %h", bus.expanded_key[1280 +: 128], gold[10]); end
      compute_gold(KEY_B);
      start_key(KEY_B);
      n_cmp++; if (bus.key_valid !== 1'b0) begin n_err++; $display("FAIL b2b_kv_e11: got %b want 0", bus.key_valid); end
      n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy_e11: got %b want 1", bus.busy); end
      n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL b2b_done_e11: got %b want 0", bus.done); end
      wait_done(n);
      n_cmp++; if (n !== 10) begin n_err++; $display("FAIL b2b_second_latency: got %0d want 10", n); end
      n_cmp++; if (bus.key_valid !== 1'b1) begin n_err++; $display("FAIL b2b_kv_e21: got %b want 1", bus.key_valid); end
      for (int i = 0; i < 11; i++) begin
         n_cmp++;
         if (bus.expanded_key[128*i +: 128] !== gold[i]) begin
            n_err++; $display("FAIL b2b_slot%0d: got %h want %h", i, bus.expanded_key[128*i +: 128], gold[i]);
         end
      end
   endtask

`ifdef AES_KEY_STREAM_EN
   task automatic test_stream();
      compute_gold(FIPS_KEY);
      start_key(FIPS_KEY);
      for (int i = 0; i < 11; i++) begin
         n_cmp++; if (bus.rk_valid !== 1'b1) begin n_err++; $display("FAIL stream_valid%0d: got %b want 1", i, bus.rk_valid); end
         n_cmp++; if (bus.rk_idx !== 4'(i)) begin n_err++; $display("FAIL stream_idx%0d: got %0d want %0d", i, bus.rk_idx, i); end
         n_cmp++; if (bus.rk !== gold[i]) begin n_err++; $display("FAIL stream_rk%0d: got %h want %h", i, bus.rk, gold[i]); end
         @(posedge clk);
         #1;
      end
      n_cmp++; if (bus.rk_valid !== 1'b0) begin n_err++; $display("FAIL stream_valid_end: got %b want 0", bus.rk_valid); end
   endtask
`endif

   initial begin
      build_sbox();
      test_reset();
      test_fips();
      test_zero_key();
      test_ignore_start();
      test_reset_mid_run();
      test_back_to_back();
`ifdef AES_KEY_STREAM_EN
      test_stream();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
